sm4_keyexp_iter: RTL

Parametrised iterative SM4 key-schedule engine that computes UNROLL rounds per clock and reuses that datapath until all 32 round keys are produced.
- Stores all 32 round keys and presents them as a 1024-bit bus, in encryption order or in reversed (decryption) order.
- Uses a valid/ready handshake on the master-key input and a level-valid on the key output.
- Adds synchronous zeroization for key hygiene.
- Sits between the key-load interface and the SM4 round pipeline; an area-scalable successor to the fully unrolled key expander.

---
 rtl/sm4_keyexp_iter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sm4_keyexp_iter.sv
// rtl/sm4_keyexp_iter.sv - iterative SM4 key schedule, UNROLL rounds per clock, 32 stored round keys
//
// Ports:
//   CLK_i       clock, rising edge
//   RST_N_i     asynchronous active-low reset
//   MK_i        128-bit master key, MK_i[127:96] is MK0
//   MK_VALID_i  master key valid
//   MK_READY_o  engine can accept a key (IDLE or DONE)
//   DEC_i       key order select latched at accept (0 = encryption, 1 = decryption)
//   ZEROIZE_i   synchronous clear of all key state, highest priority
//   RK_o        32 round keys, rk0 in [1023:992] for encryption, rk31 there for decryption
//   RK_VALID_o  RK_o complete and stable
//   BUSY_o      schedule computation in progress

module sm4_keyexp_iter #(
    parameter int UNROLL = 1
) (
    input  logic          CLK_i,
    input  logic          RST_N_i,
    input  logic [127:0]  MK_i,
    input  logic          MK_VALID_i,
    output logic          MK_READY_o,
    input  logic          DEC_i,
    input  logic          ZEROIZE_i,
    output logic [1023:0] RK_o,
    output logic          RK_VALID_o,
    output logic          BUSY_o
);

    localparam int NCYC = 32 / UNROLL;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 ||
              UNROLL == 8 || UNROLL == 16 || UNROLL == 32)) begin : g_bad_unroll
            $error("sm4_keyexp_iter: UNROLL must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          dec_q;
    logic [31:0]   k_q    [4];
    logic [31:0]   k_next [4];
    logic [31:0]   rk_q   [32];
    logic [31:0]   rk_new [UNROLL];
    logic          accept;
    logic          last_cyc;

    // Key-schedule nonlinear transform: four S-boxes followed by the
    // key-side linear mix (rotations by 13 and 23 only).
    function automatic logic [31:0] t_key(input logic [31:0] b);
        logic [31:0] s;
        s = {SBOX[b[31:24]], SBOX[b[23:16]], SBOX[b[15:8]], SBOX[b[7:0]]};
        return s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
    endfunction

    // Round constant for round r: byte i (MSB first) is (4r+i)*7 mod 256.
    function automatic logic [31:0] ck_word(input int r);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = 8'((4 * r + i) * 7);
            w = {w[23:0], b};
        end
        return w;
    endfunction

    assign last_cyc = (cnt_q == CW'(NCYC - 1));
    assign accept   = MK_VALID_i & MK_READY_o & ~ZEROIZE_i;

    // UNROLL chained rounds. The window w[0..3] is the current K state;
    // each round appends one word, and the last four become the next state.
    always_comb begin : p_rounds
        logic [31:0] w [UNROLL+4];
        for (int i = 0; i < UNROLL + 4; i++) begin
            w[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            w[i] = k_q[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            w[j+4] = w[j] ^ t_key(w[j+1] ^ w[j+2] ^ w[j+3] ^ ck_word(int'(cnt_q) * UNROLL + j));
        end
        for (int j = 0; j < UNROLL; j++) begin
            rk_new[j] = w[j+4];
        end
        for (int i = 0; i < 4; i++) begin
            k_next[i] = w[UNROLL+i];
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_fsm
        state_d    = state_q;
        MK_READY_o = 1'b0;
        RK_VALID_o = 1'b0;
        BUSY_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                MK_READY_o = 1'b1;
                if (MK_VALID_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY_o = 1'b1;
                if (last_cyc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                MK_READY_o = 1'b1;
                RK_VALID_o = 1'b1;
                if (MK_VALID_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ZEROIZE_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                k_q[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                rk_q[i] <= '0;
            end
        end else if (ZEROIZE_i) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                k_q[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                rk_q[i] <= '0;
            end
        end else if (accept) begin
            k_q[0] <= MK_i[127:96] ^ FK0;
            k_q[1] <= MK_i[95:64]  ^ FK1;
            k_q[2] <= MK_i[63:32]  ^ FK2;
            k_q[3] <= MK_i[31:0]   ^ FK3;
            dec_q  <= DEC_i;
            cnt_q  <= '0;
        end else if (state_q == ST_RUN) begin
            // Slots cnt*UNROLL .. cnt*UNROLL+UNROLL-1 receive this cycle's keys.
            for (int i = 0; i < 32; i++) begin
                if (i / UNROLL == int'(cnt_q)) begin
                    rk_q[i] <= rk_new[i % UNROLL];
                end
            end
            k_q   <= k_next;
            cnt_q <= last_cyc ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin : p_out
        RK_o = '0;
        for (int i = 0; i < 32; i++) begin
            RK_o[1023-32*i -: 32] = dec_q ? rk_q[31-i] : rk_q[i];
        end
    end

endmodule
